// File: rtl/multiply_norm_pack.sv
// multiply_norm_pack: takes a mantissa product and unbiased exponent from the
// multiplier stage, normalises it, rounds it and packs it into an IEEE-754
// single-precision word.
// Build option: define HCORDIC_ROUND_NEAREST_EN for round-to-nearest-even in
// the ROUND state; without it the mantissa is truncated and the ROUND state
// still takes its single cycle, so latency does not depend on the build.
module multiply_norm_pack (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        valid_Multiply,
    input  logic        idle_Multiply,
    input  logic [32:0] zout_Multiply,
    input  logic [49:0] productout_Multiply,
    output logic        ready_Norm,
    output logic        valid_Norm,
    output logic [31:0] result_Norm,
    output logic        overflow_Norm,
    output logic        underflow_Norm
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        NORM  = 2'd1,
        ROUND = 2'd2,
        PACK  = 2'd3
    } state_t;

    // Smallest normal exponent and largest finite exponent (unbiased).
    localparam logic signed [9:0] EXP_MIN = -10'sd126;
    localparam logic signed [9:0] EXP_MAX = 10'sd127;

    state_t             state_q, state_d;
    logic               sign_q, sign_d;
    logic signed [9:0]  exp_q, exp_d;
    logic [49:0]        m_q, m_d;
    logic [23:0]        mant_q, mant_d;
    logic               bypass_q, bypass_d;

    logic               ready_q, ready_d;
    logic               valid_q, valid_d;
    logic [31:0]        result_q, result_d;
    logic               ovf_q, ovf_d;
    logic               unf_q, unf_d;

    logic               accept;
    logic               m_zero;
    logic               shift_right;
    logic               shift_left;
    logic [24:0]        round_sum;
    logic [7:0]         exp_biased;

    assign accept = valid_Multiply & ready_q;

    // Normalisation decisions. A zero product has nothing to normalise and
    // leaves NORM straight away; otherwise denormal-range exponents are
    // pulled up to the minimum first, then the leading one is walked to
    // bit 49 while the exponent can still absorb the shift.
    assign m_zero      = (m_q == 50'd0);
    assign shift_right = !m_zero && (exp_q < EXP_MIN);
    assign shift_left  = !m_zero && !shift_right && !m_q[49] && (exp_q > EXP_MIN);

`ifdef HCORDIC_ROUND_NEAREST_EN
    // Round half to even: guard is m[25], sticky is everything below it.
    logic round_up;
    assign round_up  = m_q[25] & ((|m_q[24:0]) | m_q[26]);
    assign round_sum = {1'b0, m_q[49:26]} + {24'd0, round_up};
`else
    // Truncation: the top 24 bits of the working register are kept as-is.
    assign round_sum = {1'b0, m_q[49:26]};
`endif

    // The biased exponent only matters in the normal-number pack path, where
    // the unbiased value is in [-126, 127], so 8-bit wrap-around is exact.
    assign exp_biased = exp_q[7:0] + 8'd127;

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = idle_Multiply ? PACK : NORM;
                end
            end
            NORM: begin
                if (!shift_right && !shift_left) begin
                    state_d = ROUND;
                end
            end
            ROUND:   state_d = PACK;
            PACK:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Working-register next values: capture on accept, shift in NORM,
    // round in ROUND.
    always_comb begin
        sign_d   = sign_q;
        exp_d    = exp_q;
        m_d      = m_q;
        mant_d   = mant_q;
        bypass_d = bypass_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    sign_d   = zout_Multiply[32];
                    exp_d    = {{2{zout_Multiply[31]}}, zout_Multiply[31:24]};
                    m_d      = productout_Multiply;
                    // Bypass results reuse the incoming mantissa field directly.
                    mant_d   = zout_Multiply[23:0];
                    bypass_d = idle_Multiply;
                end
            end
            NORM: begin
                if (shift_right) begin
                    // Keep the bit that falls off as a sticky bit in bit 0.
                    m_d   = {1'b0, m_q[49:2], m_q[1] | m_q[0]};
                    exp_d = exp_q + 10'sd1;
                end else if (shift_left) begin
                    m_d   = {m_q[48:0], 1'b0};
                    exp_d = exp_q - 10'sd1;
                end
            end
            ROUND: begin
                if (round_sum[24]) begin
                    // Rounding carried out of the mantissa: renormalise.
                    mant_d = round_sum[24:1];
                    exp_d  = exp_q + 10'sd1;
                end else begin
                    mant_d = round_sum[23:0];
                end
            end
            default: ;
        endcase
    end

    // Working registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sign_q   <= 1'b0;
            exp_q    <= 10'sd0;
            m_q      <= 50'd0;
            mant_q   <= 24'd0;
            bypass_q <= 1'b0;
        end else begin
            sign_q   <= sign_d;
            exp_q    <= exp_d;
            m_q      <= m_d;
            mant_q   <= mant_d;
            bypass_q <= bypass_d;
        end
    end

    // Output logic: the packed word and flags are formed during PACK and
    // registered at the end of it, together with the valid pulse and the
    // return of ready.
    always_comb begin
        valid_d  = 1'b0;
        result_d = result_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        ready_d  = (state_d == IDLE);
        if (state_q == PACK) begin
            valid_d = 1'b1;
            ovf_d   = 1'b0;
            unf_d   = 1'b0;
            if (bypass_q) begin
                result_d = {sign_q, exp_q[7:0], mant_q[22:0]};
            end else if (exp_q > EXP_MAX) begin
                result_d = {sign_q, 8'hFF, 23'd0};
                ovf_d    = 1'b1;
            end else if (!mant_q[23]) begin
                // Denormal or zero; only a non-zero product is an underflow.
                result_d = {sign_q, 8'h00, mant_q[22:0]};
                unf_d    = !m_zero;
            end else begin
                result_d = {sign_q, exp_biased, mant_q[22:0]};
            end
        end
    end

    // Output registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ready_q  <= 1'b1;
            valid_q  <= 1'b0;
            result_q <= 32'd0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            ready_q  <= ready_d;
            valid_q  <= valid_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    assign ready_Norm     = ready_q;
    assign valid_Norm     = valid_q;
    assign result_Norm    = result_q;
    assign overflow_Norm  = ovf_q;
    assign underflow_Norm = unf_q;

endmodule

// File: tb/tb_multiply_norm_pack.sv
// Testbench for multiply_norm_pack: directed scenarios plus randomized
// transactions against an arithmetic reference model, checked by a
// scoreboard monitor.
module tb_multiply_norm_pack;

    logic        clock = 1'b0;
    logic        reset_n = 1'b1;
    logic        valid_Multiply;
    logic        idle_Multiply;
    logic [32:0] zout_Multiply;
    logic [49:0] productout_Multiply;
    logic        ready_Norm;
    logic        valid_Norm;
    logic [31:0] result_Norm;
    logic        overflow_Norm;
    logic        underflow_Norm;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int txn   = 0;

    typedef struct {
        logic [31:0] res;
        logic        ovf;
        logic        unf;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sb[$];

    multiply_norm_pack dut (
        .clock               (clock),
        .reset_n             (reset_n),
        .valid_Multiply      (valid_Multiply),
        .idle_Multiply       (idle_Multiply),
        .zout_Multiply       (zout_Multiply),
        .productout_Multiply (productout_Multiply),
        .ready_Norm          (ready_Norm),
        .valid_Norm          (valid_Norm),
        .result_Norm         (result_Norm),
        .overflow_Norm       (overflow_Norm),
        .underflow_Norm      (underflow_Norm)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // Reference model: the product is treated as a number p * 2^(e-49);
    // the shift count is derived from the leading-one position and the
    // exponent limits, then the result is rounded and packed.
    function automatic exp_t model(input logic idle, input logic [32:0] z, input logic [49:0] p);
        exp_t        r;
        int          e;
        int          k;
        int          msb;
        logic        s;
        logic [63:0] m;
        logic [24:0] mant;
        logic        g;
        logic        st;
        r.ovf = 1'b0;
        r.unf = 1'b0;
        r.acc = 0;
        if (idle) begin
            r.res = {z[32], z[31:24], z[22:0]};
            r.lat = 1;
            return r;
        end
        s = z[32];
        e = int'($signed(z[31:24]));
        if (p == 50'd0) begin
            r.res = {s, 31'd0};
            r.lat = 3;
            return r;
        end
        m = {14'd0, p};
        if (e < -126) begin
            k  = -126 - e;
            st = (m & ((64'd1 << k) - 64'd1)) != 64'd0;
            m  = (m >> k) | {63'd0, st};
            e  = -126;
        end else begin
            msb = 0;
            for (int i = 0; i < 50; i++) if (p[i]) msb = i;
            k = 49 - msb;
            if (k > e + 126) k = e + 126;
            m = m << k;
            e = e - k;
        end
        r.lat = 3 + k;
        mant = {1'b0, m[49:26]};
        g    = m[25];
        st   = (m[24:0] != 25'd0);
`ifdef HCORDIC_ROUND_NEAREST_EN
        if (g && (st || mant[0])) mant = mant + 25'd1;
        if (mant[24]) begin
            mant = mant >> 1;
            e    = e + 1;
        end
`else
        if (g && st) mant = mant;
`endif
        if (e > 127) begin
            r.res = {s, 8'hFF, 23'd0};
            r.ovf = 1'b1;
        end else if (!mant[23]) begin
            r.res = {s, 8'h00, mant[22:0]};
            r.unf = 1'b1;
        end else begin
            r.res = {s, 8'(e + 127), mant[22:0]};
        end
        return r;
    endfunction

    // Called at a negedge. While ready is low, occasionally drives a junk
    // request that must be ignored; once ready, issues the real request.
    task automatic send(input logic idle, input logic [32:0] z, input logic [49:0] p,
                        input logic use_model, input logic [31:0] dres,
                        input logic dovf, input logic dunf, input int dlat);
        exp_t x;
        int   n;
        n = 0;
        while (ready_Norm !== 1'b1 && n < 200) begin
            if ($urandom_range(0, 3) == 0) begin
                valid_Multiply      = 1'b1;
                idle_Multiply       = 1'b1;
                zout_Multiply       = {1'b1, 32'($urandom)};
                productout_Multiply = {18'($urandom), 32'($urandom)};
            end else begin
                valid_Multiply = 1'b0;
            end
            @(negedge clock);
            n++;
        end
        if (n >= 200) begin
            total++;
            bad++;
            $display("FAIL ready_timeout: got ready=%b expected 1 within 200 cycles", ready_Norm);
        end
        valid_Multiply      = 1'b1;
        idle_Multiply       = idle;
        zout_Multiply       = z;
        productout_Multiply = p;
        if (use_model) begin
            x = model(idle, z, p);
        end else begin
            x.res = dres;
            x.ovf = dovf;
            x.unf = dunf;
            x.lat = dlat;
        end
        x.acc = cyc + 1;
        sb.push_back(x);
        @(negedge clock);
        valid_Multiply = 1'b0;
    endtask

    // Monitor: pops the oldest expectation whenever a result is presented.
    initial begin
        exp_t x;
        forever begin
            @(negedge clock);
            if (reset_n === 1'b1 && valid_Norm === 1'b1) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_valid: got result %h expected no output", result_Norm);
                end else begin
                    x = sb.pop_front();
                    txn++;
                    $display("txn %0d: result=%h ovf=%b unf=%b latency=%0d (model %h/%b/%b/%0d)",
                             txn, result_Norm, overflow_Norm, underflow_Norm, cyc - x.acc,
                             x.res, x.ovf, x.unf, x.lat);
                    check("result", result_Norm, x.res);
                    check("overflow", 32'(overflow_Norm), 32'(x.ovf));
                    check("underflow", 32'(underflow_Norm), 32'(x.unf));
                    check("latency", 32'(cyc - x.acc), 32'(x.lat));
                    check("ready_with_valid", 32'(ready_Norm), 32'd1);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        valid_Multiply      = 1'b0;
        idle_Multiply       = 1'b0;
        zout_Multiply       = 33'd0;
        productout_Multiply = 50'd0;

        #2 reset_n = 1'b0;
        #1;
        check("reset_ready", 32'(ready_Norm), 32'd1);
        check("reset_valid", 32'(valid_Norm), 32'd0);
        check("reset_result", result_Norm, 32'd0);
        check("reset_flags", 32'({overflow_Norm, underflow_Norm}), 32'd0);
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);

        // 1.0 x 1.0: one left shift.
        send(1'b0, {1'b0, 8'h01, 24'h0}, 50'h1000000000000, 1'b0, 32'h3F800000, 1'b0, 1'b0, 4);
        // 1.5 x 1.5: leading one already at bit 49.
        send(1'b0, {1'b0, 8'h01, 24'hC00000}, 50'h2400000000000, 1'b0, 32'h40100000, 1'b0, 1'b0, 3);
        // Tie on the guard bit with an odd mantissa.
`ifdef HCORDIC_ROUND_NEAREST_EN
        send(1'b0, {1'b0, 8'h01, 24'h0}, 50'h1800003000000, 1'b0, 32'h3FC00002, 1'b0, 1'b0, 4);
`else
        send(1'b0, {1'b0, 8'h01, 24'h0}, 50'h1800003000000, 1'b0, 32'h3FC00001, 1'b0, 1'b0, 4);
`endif
        // Largest exponent with an all-ones mantissa and guard.
`ifdef HCORDIC_ROUND_NEAREST_EN
        send(1'b0, {1'b0, 8'h7F, 24'h0}, {25'h1FFFFFF, 25'd0}, 1'b0, 32'h7F800000, 1'b1, 1'b0, 3);
`else
        send(1'b0, {1'b0, 8'h7F, 24'h0}, {25'h1FFFFFF, 25'd0}, 1'b0, 32'h7F7FFFFF, 1'b0, 1'b0, 3);
`endif
        // Bypass of an already-final special value.
        send(1'b1, {1'b1, 8'hFF, 24'h0}, 50'd0, 1'b0, 32'hFF800000, 1'b0, 1'b0, 1);
        // Exponent -128: two sticky right shifts into a denormal.
        send(1'b0, {1'b0, 8'h80, 24'h0}, 50'h2000000000000, 1'b0, 32'h00200000, 1'b0, 1'b1, 5);
        // Zero product packs as signed zero without underflow.
        send(1'b0, {1'b1, 8'h05, 24'h0}, 50'd0, 1'b0, 32'h80000000, 1'b0, 1'b0, 3);

        // Reset in the middle of a long normalisation.
        send(1'b0, {1'b0, 8'd100, 24'h0}, 50'h100000, 1'b1, 32'd0, 1'b0, 1'b0, 0);
        repeat (3) @(negedge clock);
        #2 reset_n = 1'b0;
        #1;
        check("midreset_ready", 32'(ready_Norm), 32'd1);
        check("midreset_valid", 32'(valid_Norm), 32'd0);
        check("midreset_result", result_Norm, 32'd0);
        check("midreset_flags", 32'({overflow_Norm, underflow_Norm}), 32'd0);
        sb.delete();
        @(negedge clock);
        reset_n = 1'b1;
        repeat (60) @(negedge clock);
        send(1'b0, {1'b0, 8'h01, 24'h0}, 50'h1000000000000, 1'b0, 32'h3F800000, 1'b0, 1'b0, 4);

        // Randomized traffic, biased toward the exponent limits.
        for (int t = 0; t < 120; t++) begin
            logic [49:0] p;
            logic [32:0] z;
            int          msb;
            int          ev;
            int          sel;
            sel = int'($urandom_range(0, 3));
            if (sel == 0)      ev = -128 + int'($urandom_range(0, 8));
            else if (sel == 1) ev = 119 + int'($urandom_range(0, 8));
            else if (sel == 2) ev = -20 + int'($urandom_range(0, 40));
            else               ev = int'($urandom_range(0, 255)) - 128;
            msb = int'($urandom_range(0, 49));
            p = {18'($urandom), 32'($urandom)};
            p = p & ((50'd1 << (msb + 1)) - 50'd1);
            p[msb] = 1'b1;
            if ($urandom_range(0, 9) == 0) p = 50'd0;
            z = {1'($urandom), 8'(ev), 24'($urandom)};
            send(($urandom_range(0, 7) == 0), z, p, 1'b1, 32'd0, 1'b0, 1'b0, 0);
        end

        n = 0;
        while (sb.size() > 0 && n < 200) begin
            @(negedge clock);
            n++;
        end
        if (sb.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d outstanding results expected 0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multiply_norm_pack.md
MULTIPLY_NORM_PACK -- requirements
Module: multiply_norm_pack

Interface
REQ-001 The block SHALL have no parameters.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-003 clock  in  1  rising-edge clock.
REQ-004 reset_n  in  1  asynchronous active-low reset.
REQ-005 valid_Multiply  in  1  product available; accepted only while ready_Norm=1.
REQ-006 idle_Multiply  in  1  1 = zout_Multiply already final (special case); 0 = normalise product.
REQ-007 zout_Multiply  in  33  [32] sign, [31:24] unbiased exponent (8-bit two's complement), [23:0] mantissa, hidden bit at [23].
REQ-008 productout_Multiply  in  50  mantissa product ×4; bit 49 weighs 2^0 relative to the exponent.
REQ-009 ready_Norm  out  1  block in IDLE, able to accept.
REQ-010 valid_Norm  out  1  one-cycle pulse; result_Norm valid.
REQ-011 result_Norm  out  32  IEEE-754 single-precision result, held until next pack.
REQ-012 overflow_Norm / underflow_Norm  out  1 each  status for the current result_Norm.

Function
REQ-013 States SHALL be IDLE, NORM, ROUND and PACK.
REQ-014 Accept rule: at the edge where valid_Multiply=1 and ready_Norm=1, the block SHALL capture inputs.
  - Sign s = zout[32].
  - Exponent e = 10-bit sign-extension of zout[31:24].
  - Working register m = productout[49:0].
REQ-015 After capture, the next state SHALL be NORM if idle_Multiply=0, else PACK (bypass).
REQ-016 valid_Multiply while ready_Norm=0 SHALL be ignored; there is no buffering.
REQ-017 NORM SHALL evaluate once per cycle, in this priority order:
  - If e<-126: m shifts right 1 with bit0 OR-ed with the shifted-out bit (sticky); e increments.
  - Else if m[49]=0, m≠0 and e>-126: m shifts left 1; e decrements.
  - Else: go to ROUND.
REQ-018 Product m=0 SHALL leave NORM immediately and pack as signed zero.
REQ-019 ROUND SHALL take one cycle.
  - Fields: mantissa M=m[49:26], guard G=m[25], sticky S=|m[24:0].
  - Round to nearest even: increment M when G & (S | M[0]).
  - Carry-out to 25 bits: M shifts right 1 and e increments.
REQ-020 PACK SHALL take one cycle and drive valid_Norm=1. Normal case:
  - If e>127: result_Norm={s,8'hFF,23'h0}, overflow_Norm=1.
  - Else if M[23]=0: result_Norm={s,8'h00,M[22:0]}; underflow_Norm=1 if any product bit was nonzero.
  - Else: result_Norm={s,e+127,M[22:0]}.
REQ-021 Bypass PACK SHALL set result_Norm={zout[32],zout[31:24],zout[22:0]} with both flags 0.
REQ-022 Latency (accept edge to valid_Norm high) SHALL be:
  - Bypass: 1 cycle.
  - Leading one at bit 49: 3 cycles.
  - Otherwise: +1 cycle per NORM shift.
REQ-023 ready_Norm SHALL be registered, high exactly in IDLE, and rise on the same edge valid_Norm rises, so back-to-back acceptance is possible during the valid_Norm cycle.
REQ-024 Flags SHALL update only in PACK.

Reset
REQ-025 reset_n=0 SHALL immediately force state IDLE and set outputs: ready_Norm=1, valid_Norm=0, result_Norm=0, both flags 0, regardless of state.
REQ-026 Reset asserted mid-operation SHALL abandon that operation; no valid_Norm pulse for it after release.

Configuration
REQ-027 With macro HCORDIC_ROUND_NEAREST_EN defined, ROUND SHALL behave per REQ-019.
REQ-028 Without HCORDIC_ROUND_NEAREST_EN, ROUND SHALL truncate (M=m[49:26], no increment), and ROUND state and latency SHALL be unchanged.

Verification
REQ-029 Scenario 1: 1.0×1.0, zout={0,8'h01,24'h0}, product=2^48 -> one left shift, result_Norm=32'h3F800000, valid_Norm 4 cycles after accept.
REQ-030 Scenario 2: 1.5×1.5, zout exp 8'h01, product=2.25·2^48 (bit 49 set) -> result_Norm=32'h40100000, latency 3.
REQ-031 Scenario 3: 0x800001×0xC00000, exp 8'h01, product=2^48+2^47+2^25+2^24 -> 32'h3FC00002 with macro, 32'h3FC00001 without.
REQ-032 Scenario 4: exp 8'h7F, product bits [49:25] all ones, rest 0 -> with macro 32'h7F800000 and overflow_Norm=1; without macro 32'h7F7FFFFF, overflow_Norm=0.
REQ-033 Scenario 5: idle_Multiply=1, zout={1,8'hFF,24'h0} -> result_Norm=32'hFF800000, valid_Norm 1 cycle after accept.
REQ-034 Scenario 6: reset_n low during NORM -> outputs at reset values immediately, no valid_Norm after release, next accept completes normally.
